// File: rtl/shot_sequencer.sv
// shot_sequencer: run-level controller for the DSP shot datapath (dspclk domain).
// A start strobe clears the accumulators, then nshot trigger pulses are issued.
// After each trigger the block waits for the processing-done pulse and then
// idles for the programmed inter-shot delay. Abort and a per-shot watchdog
// can end a run early.
//
// Ports:
//   clk, reset      dspclk, asynchronous active-high reset
//   stb_start       1-cycle pulse, begins a run (ignored while busy)
//   stb_abort       1-cycle pulse, ends a run in progress
//   nshot           shots per run, latched at start
//   delayaftertrig  idle cycles between procdone and the next trigger, latched at start
//   timeout         watchdog limit per shot (0 = disabled), latched at start
//   procdone        1-cycle pulse from the DSP, current shot finished
//   stb_shot        1-cycle trigger per shot
//   stb_resetacc    1-cycle accumulator clear at run start
//   shotcnt         completed shots in the current/last run
//   lastshotdone    level, run completed all nshot shots
//   busy            level, run in progress
//   timeout_err     sticky, watchdog expired; cleared by the next accepted start
module shot_sequencer #(
    parameter int unsigned NSHOTWIDTH   = 20,
    parameter int unsigned DELAYWIDTH   = 16,
    parameter int unsigned TIMEOUTWIDTH = 24
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stb_start,
    input  logic                    stb_abort,
    input  logic [NSHOTWIDTH-1:0]   nshot,
    input  logic [DELAYWIDTH-1:0]   delayaftertrig,
    input  logic [TIMEOUTWIDTH-1:0] timeout,
    input  logic                    procdone,
    output logic                    stb_shot,
    output logic                    stb_resetacc,
    output logic [NSHOTWIDTH-1:0]   shotcnt,
    output logic                    lastshotdone,
    output logic                    busy,
    output logic                    timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_TRIG,
        S_WAIT,
        S_DELAY
    } state_t;

    state_t                  state_q, state_d;
    logic [NSHOTWIDTH-1:0]   nshot_q, nshot_d;
    logic [DELAYWIDTH-1:0]   delay_q, delay_d;
    logic [TIMEOUTWIDTH-1:0] timeout_q, timeout_d;
    logic [DELAYWIDTH-1:0]   dly_cnt_q, dly_cnt_d;
    logic [TIMEOUTWIDTH-1:0] wd_cnt_q, wd_cnt_d;
    logic [NSHOTWIDTH-1:0]   shotcnt_q, shotcnt_d;
    logic                    lastshotdone_q, lastshotdone_d;
    logic                    timeout_err_q, timeout_err_d;
    logic                    stb_shot_q, stb_shot_d;
    logic                    stb_resetacc_q, stb_resetacc_d;
    logic                    busy_q, busy_d;
    logic [NSHOTWIDTH-1:0]   shot_inc;

    always_comb begin
        state_d        = state_q;
        nshot_d        = nshot_q;
        delay_d        = delay_q;
        timeout_d      = timeout_q;
        dly_cnt_d      = dly_cnt_q;
        wd_cnt_d       = wd_cnt_q;
        shotcnt_d      = shotcnt_q;
        lastshotdone_d = lastshotdone_q;
        timeout_err_d  = timeout_err_q;
        stb_shot_d     = 1'b0;
        stb_resetacc_d = 1'b0;
        shot_inc       = shotcnt_q + 1'b1;

        // Pulse outputs are registered, so each is raised on the transition
        // into the state that owns it.
        case (state_q)
            S_IDLE: begin
                if (stb_start) begin
                    timeout_err_d = 1'b0;
                    if (nshot != '0) begin
                        nshot_d        = nshot;
                        delay_d        = delayaftertrig;
                        timeout_d      = timeout;
                        lastshotdone_d = 1'b0;
                        stb_resetacc_d = 1'b1;
                        state_d        = S_CLEAR;
                    end else begin
                        lastshotdone_d = 1'b1;
                        shotcnt_d      = '0;
                    end
                end
            end
            S_CLEAR: begin
                shotcnt_d  = '0;
                stb_shot_d = 1'b1;
                state_d    = S_TRIG;
            end
            S_TRIG: begin
                wd_cnt_d = '0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                // wd_cnt_d counts cycles elapsed since the trigger pulse.
                wd_cnt_d = wd_cnt_q + 1'b1;
                if (procdone) begin
                    shotcnt_d = shot_inc;
                    if (shot_inc == nshot_q) begin
                        lastshotdone_d = 1'b1;
                        state_d        = S_IDLE;
                    end else if (delay_q == '0) begin
                        stb_shot_d = 1'b1;
                        state_d    = S_TRIG;
                    end else begin
                        dly_cnt_d = delay_q;
                        state_d   = S_DELAY;
                    end
                end else if (timeout_q != '0 &&
                             wd_cnt_d >= TIMEOUTWIDTH'(timeout_q - 1'b1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            S_DELAY: begin
                if (dly_cnt_q == DELAYWIDTH'(1)) begin
                    stb_shot_d = 1'b1;
                    state_d    = S_TRIG;
                end else begin
                    dly_cnt_d = dly_cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides every other event of the cycle, including a
        // simultaneous procdone (shotcnt holds) and any pulse about to fire.
        if (stb_abort && state_q != S_IDLE) begin
            state_d        = S_IDLE;
            stb_shot_d     = 1'b0;
            stb_resetacc_d = 1'b0;
            shotcnt_d      = shotcnt_q;
            lastshotdone_d = lastshotdone_q;
            timeout_err_d  = timeout_err_q;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            nshot_q        <= '0;
            delay_q        <= '0;
            timeout_q      <= '0;
            dly_cnt_q      <= '0;
            wd_cnt_q       <= '0;
            shotcnt_q      <= '0;
            lastshotdone_q <= 1'b0;
            timeout_err_q  <= 1'b0;
            stb_shot_q     <= 1'b0;
            stb_resetacc_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            nshot_q        <= nshot_d;
            delay_q        <= delay_d;
            timeout_q      <= timeout_d;
            dly_cnt_q      <= dly_cnt_d;
            wd_cnt_q       <= wd_cnt_d;
            shotcnt_q      <= shotcnt_d;
            lastshotdone_q <= lastshotdone_d;
            timeout_err_q  <= timeout_err_d;
            stb_shot_q     <= stb_shot_d;
            stb_resetacc_q <= stb_resetacc_d;
            busy_q         <= busy_d;
        end
    end

    assign stb_shot     = stb_shot_q;
    assign stb_resetacc = stb_resetacc_q;
    assign shotcnt      = shotcnt_q;
    assign lastshotdone = lastshotdone_q;
    assign busy         = busy_q;
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_shot_sequencer.sv
// Testbench for shot_sequencer: a timeline model predicts, per cycle, every
// output of a run from its parameters and the procdone latency of each shot.
module tb_shot_sequencer;

    localparam int NW = 20;
    localparam int DW = 16;
    localparam int TW = 24;
    localparam int NC = 256;

    logic          clk = 1'b0;
    logic          reset;
    logic          stb_start;
    logic          stb_abort;
    logic [NW-1:0] nshot;
    logic [DW-1:0] delayaftertrig;
    logic [TW-1:0] timeout;
    logic          procdone;
    logic          stb_shot;
    logic          stb_resetacc;
    logic [NW-1:0] shotcnt;
    logic          lastshotdone;
    logic          busy;
    logic          timeout_err;

    shot_sequencer #(
        .NSHOTWIDTH  (NW),
        .DELAYWIDTH  (DW),
        .TIMEOUTWIDTH(TW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stb_start     (stb_start),
        .stb_abort     (stb_abort),
        .nshot         (nshot),
        .delayaftertrig(delayaftertrig),
        .timeout       (timeout),
        .procdone      (procdone),
        .stb_shot      (stb_shot),
        .stb_resetacc  (stb_resetacc),
        .shotcnt       (shotcnt),
        .lastshotdone  (lastshotdone),
        .busy          (busy),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Values the outputs hold at the end of the previous run.
    int prev_cnt  = 0;
    int prev_last = 0;
    int prev_err  = 0;

    int lat[8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " shot"}, 32'(stb_shot), 0);
        check({tag, " racc"}, 32'(stb_resetacc), 0);
        check({tag, " cnt"}, 32'(shotcnt), 0);
        check({tag, " last"}, 32'(lastshotdone), 0);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " terr"}, 32'(timeout_err), 0);
    endtask

    // abort_at: -1 none, -2 random cycle inside the run, >=0 fixed cycle.
    // stop_at:  >=0 returns before that cycle (for the mid-run reset test).
    task automatic run_seq(input string name, input int ns, input int dl, input int tm,
                           input int lats[8], input int abort_at, input int stop_at);
        int e_shot[NC], e_racc[NC], e_busy[NC], e_cnt[NC], e_last[NC], e_err[NC], pd[NC];
        int endc, s, t, kexp, ab, w;
        for (int n = 0; n < NC; n++) begin
            e_shot[n] = 0; e_racc[n] = 0; e_busy[n] = 0; pd[n] = 0;
            e_cnt[n] = prev_cnt; e_last[n] = prev_last; e_err[n] = prev_err;
        end
        if (ns == 0) begin
            for (int n = 1; n < NC; n++) begin
                e_last[n] = 1; e_cnt[n] = 0; e_err[n] = 0;
            end
            endc = 1;
        end else begin
            for (int n = 1; n < NC; n++) begin
                e_err[n] = 0; e_last[n] = 0;
            end
            e_racc[1] = 1;
            for (int n = 2; n < NC; n++) e_cnt[n] = 0;
            s = 2;
            endc = 0;
            kexp = (tm == 0) ? 1 << 30 : ((tm - 1 < 1) ? 1 : tm - 1);
            for (int i = 1; i <= ns; i++) begin
                e_shot[s] = 1;
                if (lats[i-1] > kexp) begin
                    for (int n = s + kexp + 1; n < NC; n++) e_err[n] = 1;
                    endc = s + kexp + 1;
                    break;
                end
                t = s + lats[i-1];
                pd[t] = 1;
                for (int n = t + 1; n < NC; n++) e_cnt[n] = i;
                if (i == ns) begin
                    for (int n = t + 1; n < NC; n++) e_last[n] = 1;
                    endc = t + 1;
                    break;
                end
                s = t + 1 + dl;
            end
            for (int n = 1; n < endc; n++) e_busy[n] = 1;
        end
        ab = abort_at;
        if (ab == -2) ab = (ns == 0) ? -1 : int'($urandom_range(2, endc - 1));
        if (ab >= 0) begin
            for (int n = ab + 1; n < NC; n++) begin
                e_shot[n] = 0; e_racc[n] = 0; e_busy[n] = 0;
                e_cnt[n] = e_cnt[ab]; e_last[n] = e_last[ab]; e_err[n] = e_err[ab];
            end
        end
        w = endc + 4;
        for (int n = 0; n < w; n++) begin
            if (n == stop_at) return;
            @(negedge clk);
            check($sformatf("%s shot@%0d", name, n), 32'(stb_shot), 32'(e_shot[n]));
            check($sformatf("%s racc@%0d", name, n), 32'(stb_resetacc), 32'(e_racc[n]));
            check($sformatf("%s busy@%0d", name, n), 32'(busy), 32'(e_busy[n]));
            check($sformatf("%s cnt@%0d", name, n), 32'(shotcnt), 32'(e_cnt[n]));
            check($sformatf("%s last@%0d", name, n), 32'(lastshotdone), 32'(e_last[n]));
            check($sformatf("%s terr@%0d", name, n), 32'(timeout_err), 32'(e_err[n]));
            // Extra start while busy and a stray procdone in CLEAR must both be ignored.
            stb_start = (n == 0) || (n == 3 && ns != 0);
            stb_abort = (n == ab);
            procdone  = (pd[n] != 0) || (n == 1);
            if (n == 0) begin
                nshot = NW'(ns); delayaftertrig = DW'(dl); timeout = TW'(tm);
            end else begin
                nshot = NW'($urandom_range(0, 9));
                delayaftertrig = DW'($urandom_range(0, 9));
                timeout = TW'($urandom_range(0, 9));
            end
        end
        prev_cnt  = e_cnt[w-1];
        prev_last = e_last[w-1];
        prev_err  = e_err[w-1];
    endtask

    initial begin
        reset = 1'b1;
        stb_start = 1'b0; stb_abort = 1'b0; procdone = 1'b0;
        nshot = '0; delayaftertrig = '0; timeout = '0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;

        // nshot=3, delay 0, procdone 5 cycles after each trigger: shots at 2,8,14.
        foreach (lat[i]) lat[i] = 5;
        run_seq("basic", 3, 0, 0, lat, -1, -1);
        // nshot=2, delay 4: 5-cycle gap from procdone to next trigger.
        foreach (lat[i]) lat[i] = 3;
        run_seq("delay", 2, 4, 0, lat, -1, -1);
        run_seq("zero", 0, 2, 0, lat, -1, -1);
        // Watchdog: procdone withheld, timeout 10.
        foreach (lat[i]) lat[i] = 1000;
        run_seq("wdog", 2, 1, 10, lat, -1, -1);
        // Next start clears timeout_err; procdone exactly at the watchdog limit wins.
        foreach (lat[i]) lat[i] = 9;
        run_seq("wdedge", 2, 0, 10, lat, -1, -1);
        // nshot=5, abort with the 2nd procdone (cycle 9).
        foreach (lat[i]) lat[i] = 3;
        run_seq("abort", 5, 0, 0, lat, 9, -1);

        // Reset asserted during DELAY (cycles 5..10 of this run).
        foreach (lat[i]) lat[i] = 2;
        run_seq("rstmid", 2, 6, 0, lat, -1, 7);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check_zero("rstmid async");
        stb_start = 1'b0; stb_abort = 1'b0; procdone = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        prev_cnt = 0; prev_last = 0; prev_err = 0;
        foreach (lat[i]) lat[i] = 4;
        run_seq("afterrst", 3, 2, 0, lat, -1, -1);

        for (int r = 0; r < 40; r++) begin
            int ns, dl, tm, ab;
            ns = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
            dl = $urandom_range(0, 6);
            tm = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 25));
            foreach (lat[i]) lat[i] = $urandom_range(1, 20);
            ab = ($urandom_range(0, 3) == 0) ? -2 : -1;
            run_seq($sformatf("rnd%0d", r), ns, dl, tm, lat, ab, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
